// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF synchronised rx, mid-bit sampling, valid/ready delivery.
// Define UART_RX_PARITY_EN to expect one parity bit (odd/even via PARITY_ODD) after the data.
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] result,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_chk_clks
        $error("uart_rx_cfg: CLKS_PER_BIT must be even and >= 4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity
        $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 armed;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitcnt;
    logic                 stopcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 done;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic perr_acc;
    logic perr_held;
    assign parity_err = perr_held;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            armed     <= 1'b0;
            state     <= StIdle;
            cnt       <= '0;
            bitcnt    <= '0;
            stopcnt   <= 1'b0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc  <= 1'b0;
            perr_held <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            if (rx_s) begin
                armed <= 1'b1;
            end
            done    <= 1'b0;
            overrun <= 1'b0;
            cnt     <= cnt + 1'b1;

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (armed && !rx_s) begin
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (cnt == CNT_MID) begin
                        cnt      <= '0;
                        bitcnt   <= '0;
                        stopcnt  <= 1'b0;
                        ferr_acc <= 1'b0;
                        // A high line at mid-start is a glitch, not a frame.
                        state    <= rx_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (cnt == CNT_END) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
                StParity: begin
                    if (cnt == CNT_END) begin
                        cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                        perr_acc <= ((^shreg) ^ rx_s) != PAR_ODD;
`endif
                        state <= StStop;
                    end
                end
                StStop: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        stopcnt <= stopcnt + 1'b1;
                        if (!rx_s) begin
                            ferr_acc <= 1'b1;
                        end
                        // Leave at mid-stop so the next start edge is caught early.
                        if (stopcnt == LAST_STOP) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase

            if (done) begin
                if (!valid || ready) begin
                    result    <= shreg;
                    valid     <= 1'b1;
                    frame_err <= ferr_acc;
`ifdef UART_RX_PARITY_EN
                    perr_held <= perr_acc;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid     <= 1'b0;
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_held <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg (CLKS_PER_BIT=4, 8 data bits, 1 stop bit).
// Expected words are queued as frames are driven and compared when valid appears.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int DB   = 8;
    localparam int CPB  = 4;
    localparam int SB   = 1;
    localparam int PODD = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          ready;
    logic [DB-1:0] result;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .result     (result),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   ovr_cnt  = 0;
    int   busy_cnt = 0;
    int   perr_cnt = 0;

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopv,
                              input bit deliver);
        exp_t e;
        e.data = d;
        e.ferr = ~stopv;
`ifdef UART_RX_PARITY_EN
        e.perr = (^d) ^ pbit ^ (PODD != 0);
`else
        e.perr = 1'b0;
`endif
        if (deliver) expq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        for (int i = 0; i < SB; i++) drive_bit(stopv);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: valid never rose within 40 cycles", name);
        end
    endtask

    task automatic pulse_ready;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        exp_t e;
        bit   ok;
        int   o0;
        o0 = ovr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_valid("basic", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL basic_result: got %h want %h", result, e.data); end
            checks++; if (frame_err !== e.ferr) begin failures++; $display("FAIL basic_frame_err: got %b want %b", frame_err, e.ferr); end
            checks++; if (parity_err !== e.perr) begin failures++; $display("FAIL basic_parity_err: got %b want %b", parity_err, e.perr); end
        end
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL basic_hold_valid: got %b want 1", valid); end
        pulse_ready();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_handshake_valid: got %b want 0", valid); end
        checks++; if (result !== 8'hA5) begin failures++; $display("FAIL basic_result_hold: got %h want a5", result); end
        checks++; if (ovr_cnt !== o0) begin failures++; $display("FAIL basic_overrun: got %0d pulses want 0", ovr_cnt - o0); end
    endtask

    task automatic test_glitch;
        int b0;
        int o0;
        b0 = busy_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy_cnt <= b0) begin failures++; $display("FAIL glitch_busy_rose: got %0d busy cycles want >0", busy_cnt - b0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fell: got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
        checks++; if (ovr_cnt !== o0) begin failures++; $display("FAIL glitch_overrun: got %0d pulses want 0", ovr_cnt - o0); end
    endtask

    task automatic test_frame_err;
        exp_t e;
        bit   ok;
        int   o0;
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_valid("frame_err", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL ferr_result: got %h want %h", result, e.data); end
            checks++; if (frame_err !== e.ferr) begin failures++; $display("FAIL ferr_frame_err: got %b want %b", frame_err, e.ferr); end
        end
        repeat (10) @(negedge clk);
        checks++; if (ovr_cnt !== o0) begin failures++; $display("FAIL ferr_overrun: got %0d pulses want 0", ovr_cnt - o0); end
        pulse_ready();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_cleared: got %b want 0", frame_err); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   ok;
        int   o0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        wait_valid("b2b", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL b2b_result: got %h want %h", result, e.data); end
        end
        checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL b2b_overrun: got %0d pulses want 1", ovr_cnt - o0); end
        pulse_ready();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_clear: got %b want 0", valid); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_parity;
        exp_t e;
        bit   ok;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        wait_valid("parity_bad", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL par_bad_result: got %h want %h", result, e.data); end
            checks++; if (parity_err !== e.perr) begin failures++; $display("FAIL par_bad_parity_err: got %b want %b", parity_err, e.perr); end
        end
        pulse_ready();
        repeat (4) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_valid("parity_good", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL par_good_result: got %h want %h", result, e.data); end
            checks++; if (parity_err !== e.perr) begin failures++; $display("FAIL par_good_parity_err: got %b want %b", parity_err, e.perr); end
        end
`else
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        wait_valid("parity_off", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL par_off_result: got %h want %h", result, e.data); end
            checks++; if (parity_err !== e.perr) begin failures++; $display("FAIL par_off_parity_err: got %b want %b", parity_err, e.perr); end
        end
        checks++; if (perr_cnt !== 0) begin failures++; $display("FAIL par_off_never_set: got %0d cycles want 0", perr_cnt); end
`endif
        pulse_ready();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        exp_t e;
        bit   ok;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rstmid_held_word: got valid %b want 1", valid); end
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_in_frame: got busy %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL rstmid_result: got %h want 00", result); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_flags: got f=%b p=%b o=%b want 000", frame_err, parity_err, overrun);
        end
        repeat (12 * CPB) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_valid("rstmid_next", ok);
        if (ok) begin
            e = expq.pop_front();
            checks++; if (result !== e.data) begin failures++; $display("FAIL rstmid_next_result: got %h want %h", result, e.data); end
            checks++; if (frame_err !== e.ferr || parity_err !== e.perr) begin
                failures++;
                $display("FAIL rstmid_next_flags: got f=%b p=%b want f=%b p=%b", frame_err, parity_err, e.ferr, e.perr);
            end
        end
        pulse_ready();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_next_clear: got %b want 0", valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
